// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and 8N1 frame constants,
// also used by the transmitter and echo logic.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DEFAULT_DATA_BITS    = 8;
  // start + 8 data + stop
  localparam int FRAME_BITS_8N1       = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/rxd_sync.sv
// Two-flop synchronizer for an asynchronous level input. Both flops reset to 1
// so an idle-high serial line never shows a false start edge out of reset.
module rxd_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_frame_receiver.sv
// 8N1 UART receiver: synchronizes rxd, samples each bit at mid-period and
// presents completed bytes on word with a level ready / pulsed ack handshake.
module uart_frame_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] word,
  output logic                 recieve_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun,
  output rx_state_t            state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

  logic                 rxs;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 load_pend;
  logic                 stop_hold;

  rxd_sync u_rxd_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (rxd),
    .dout (rxs)
  );

  // Handshake: word is valid while recieve_ready is high; the consumer pulses
  // rd_ack for one cycle to take it, and ready drops on the following edge.
  // A byte completing while ready is still high (and no ack) sets overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shreg         <= '0;
      load_pend     <= 1'b0;
      stop_hold     <= 1'b0;
      frame_err     <= 1'b0;
      busy          <= 1'b0;
      word          <= '0;
      recieve_ready <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      load_pend <= 1'b0;
      frame_err <= 1'b0;
      busy      <= (state != IDLE);

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxs) state <= START;
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_LAST) begin
            cnt        <= '0;
            shreg[idx] <= rxs;
            if (idx == LAST_IDX) state <= STOP;
            else idx <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // After a bad stop bit, wait out a break before re-arming.
          if (stop_hold) begin
            if (rxs) begin
              stop_hold <= 1'b0;
              state     <= IDLE;
            end
          end else if (cnt == FULL_LAST) begin
            cnt <= '0;
            if (rxs) begin
              load_pend <= 1'b1;
              state     <= IDLE;
            end else begin
              frame_err <= 1'b1;
              stop_hold <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (load_pend) begin
        word          <= shreg;
        recieve_ready <= 1'b1;
        if (recieve_ready && !rd_ack) overrun <= 1'b1;
        else if (rd_ack)              overrun <= 1'b0;
      end else if (rd_ack) begin
        recieve_ready <= 1'b0;
        overrun       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Directed bench for uart_frame_receiver at default 8N1 timing (16 clocks/bit).
module tb_uart_frame_receiver;
  import uart_pkg::*;

  localparam int CLKS = 16;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic       rd_ack;
  logic [7:0] word;
  logic       recieve_ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  rx_state_t  state;

  int checks = 0;
  int fails  = 0;
  int err_count = 0;

  uart_frame_receiver #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd),
    .rd_ack        (rd_ack),
    .word          (word),
    .recieve_ready (recieve_ready),
    .busy          (busy),
    .frame_err     (frame_err),
    .overrun       (overrun),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) err_count++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // start bit plus data bits, LSB first; returns at the end of the last data bit
  task automatic send_head(input logic [7:0] data);
    rxd = 1'b0;
    tick(CLKS);
    for (int k = 0; k < 8; k++) begin
      rxd = data[k];
      tick(CLKS);
    end
  endtask

  task automatic send_frame(input logic [7:0] data);
    send_head(data);
    rxd = 1'b1;
    tick(CLKS);
  endtask

  task automatic pulse_ack();
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rxd = 1'b1; rd_ack = 1'b0;
    tick(4);
    checks++; if (word !== 8'h00) begin fails++; $display("FAIL reset_word: got %h expected 00", word); end
    checks++; if (recieve_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", recieve_ready); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (state !== IDLE) begin fails++; $display("FAIL reset_state: got %0d expected 0", state); end
    rst = 1'b0;
    tick(3);
    pulse_ack();
    checks++; if (recieve_ready !== 1'b0 || overrun !== 1'b0) begin fails++; $display("FAIL idle_ack: got ready=%b overrun=%b expected 0 0", recieve_ready, overrun); end
  endtask

  task automatic test_basic();
    int e0;
    logic [7:0] d;
    e0 = err_count;
    d = 8'h55;
    rxd = 1'b0;
    tick(3);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_t2: got %b expected 0", busy); end
    tick(1);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_t3: got %b expected 1", busy); end
    tick(12);
    for (int k = 0; k < 8; k++) begin
      rxd = d[k];
      tick(CLKS);
    end
    rxd = 1'b1;
    tick(11);
    checks++; if (recieve_ready !== 1'b0) begin fails++; $display("FAIL basic_ready_t154: got %b expected 0", recieve_ready); end
    tick(1);
    checks++; if (recieve_ready !== 1'b1) begin fails++; $display("FAIL basic_ready_t155: got %b expected 1", recieve_ready); end
    checks++; if (word !== 8'h55) begin fails++; $display("FAIL basic_word: got %h expected 55", word); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL basic_overrun: got %b expected 0", overrun); end
    tick(4);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    checks++; if (err_count - e0 !== 0) begin fails++; $display("FAIL basic_frame_err: got %0d pulses expected 0", err_count - e0); end
  endtask

  task automatic test_back_to_back();
    pulse_ack();
    checks++; if (recieve_ready !== 1'b0) begin fails++; $display("FAIL b2b_ack0: got %b expected 0", recieve_ready); end
    send_frame(8'hA3);
    checks++; if (word !== 8'hA3 || recieve_ready !== 1'b1) begin fails++; $display("FAIL b2b_first: got word=%h ready=%b expected A3 1", word, recieve_ready); end
    pulse_ack();
    checks++; if (recieve_ready !== 1'b0) begin fails++; $display("FAIL b2b_ack1: got %b expected 0", recieve_ready); end
    send_frame(8'h0F);
    checks++; if (word !== 8'h0F || recieve_ready !== 1'b1) begin fails++; $display("FAIL b2b_second: got word=%h ready=%b expected 0F 1", word, recieve_ready); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
    pulse_ack();
  endtask

  task automatic test_overrun();
    send_frame(8'h12);
    checks++; if (word !== 8'h12 || overrun !== 1'b0) begin fails++; $display("FAIL ovr_first: got word=%h overrun=%b expected 12 0", word, overrun); end
    send_frame(8'h34);
    checks++; if (word !== 8'h34 || recieve_ready !== 1'b1) begin fails++; $display("FAIL ovr_second: got word=%h ready=%b expected 34 1", word, recieve_ready); end
    checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    tick(10);
    checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    pulse_ack();
    checks++; if (recieve_ready !== 1'b0 || overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear: got ready=%b overrun=%b expected 0 0", recieve_ready, overrun); end
  endtask

  task automatic test_ack_collision();
    send_frame(8'h66);
    checks++; if (word !== 8'h66 || recieve_ready !== 1'b1) begin fails++; $display("FAIL coll_pre: got word=%h ready=%b expected 66 1", word, recieve_ready); end
    send_head(8'hC5);
    rxd = 1'b1;
    tick(11);
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    checks++; if (word !== 8'hC5) begin fails++; $display("FAIL coll_word: got %h expected C5", word); end
    checks++; if (recieve_ready !== 1'b1) begin fails++; $display("FAIL coll_ready: got %b expected 1", recieve_ready); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL coll_overrun: got %b expected 0", overrun); end
    tick(4);
  endtask

  task automatic test_frame_error();
    int e0;
    e0 = err_count;
    send_head(8'hFF);
    rxd = 1'b0;
    tick(CLKS + 40);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL ferr_busy_break: got %b expected 1", busy); end
    checks++; if (word !== 8'hC5 || recieve_ready !== 1'b1) begin fails++; $display("FAIL ferr_word_kept: got word=%h ready=%b expected C5 1", word, recieve_ready); end
    rxd = 1'b1;
    tick(5);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL ferr_busy_release: got %b expected 0", busy); end
    checks++; if (err_count - e0 !== 1) begin fails++; $display("FAIL ferr_pulses: got %0d expected 1", err_count - e0); end
    checks++; if (word !== 8'hC5 || overrun !== 1'b0) begin fails++; $display("FAIL ferr_after: got word=%h overrun=%b expected C5 0", word, overrun); end
    pulse_ack();
  endtask

  task automatic test_glitch();
    int e0;
    e0 = err_count;
    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    tick(3);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL glitch_busy: got %b expected 1", busy); end
    tick(10);
    checks++; if (busy !== 1'b0 || state !== IDLE) begin fails++; $display("FAIL glitch_idle: got busy=%b state=%0d expected 0 0", busy, state); end
    checks++; if (recieve_ready !== 1'b0 || overrun !== 1'b0 || err_count != e0) begin fails++; $display("FAIL glitch_flags: got ready=%b overrun=%b err=%0d expected 0 0 0", recieve_ready, overrun, err_count - e0); end
    send_frame(8'h81);
    checks++; if (word !== 8'h81 || recieve_ready !== 1'b1) begin fails++; $display("FAIL glitch_next: got word=%h ready=%b expected 81 1", word, recieve_ready); end
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    logic [7:0] d;
    d = 8'hAA;
    rxd = 1'b0;
    tick(CLKS);
    for (int k = 0; k < 4; k++) begin
      rxd = d[k];
      tick(CLKS);
    end
    rxd = d[4];
    tick(CLKS / 2);
    rst = 1'b1;
    rxd = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++; if (word !== 8'h00 || recieve_ready !== 1'b0) begin fails++; $display("FAIL mid_rst_word: got word=%h ready=%b expected 00 0", word, recieve_ready); end
    checks++; if (busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0 || state !== IDLE) begin fails++; $display("FAIL mid_rst_flags: got busy=%b ferr=%b ovr=%b state=%0d expected 0 0 0 0", busy, frame_err, overrun, state); end
    tick(20);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_rst_quiet: got %b expected 0", busy); end
    e0 = err_count;
    send_frame(8'h3C);
    checks++; if (word !== 8'h3C || recieve_ready !== 1'b1 || overrun !== 1'b0) begin fails++; $display("FAIL mid_rst_resend: got word=%h ready=%b ovr=%b expected 3C 1 0", word, recieve_ready, overrun); end
    checks++; if (err_count != e0) begin fails++; $display("FAIL mid_rst_ferr: got %0d expected 0", err_count - e0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_ack_collision();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
